// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state, instruction-class, ALU/extender and opcode
// encodings shared by the multi-cycle MIPS control FSM and its decoder.
package multicycle_ctrl_pkg;

  localparam logic [4:0] JAL_REG = 5'd31;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB_I   = 4'd5,
    S_MEMADR = 4'd6,
    S_MEMRD  = 4'd7,
    S_MEMWB  = 4'd8,
    S_MEMWR  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
  } iclass_t;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;
  localparam logic [3:0] ALUOP_AND = 4'd2;
  localparam logic [3:0] ALUOP_OR  = 4'd3;
  localparam logic [3:0] ALUOP_SLT = 4'd4;
  localparam logic [3:0] ALUOP_LUI = 4'd5;

  localparam logic [1:0] EXTOP_ZERO   = 2'd0;
  localparam logic [1:0] EXTOP_SIGNED = 2'd1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/mctrl_decode.sv
// mctrl_decode: combinational opcode/funct -> instruction class,
// execute-stage alu_op/ext_op and illegal flag.
module mctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls,
  output logic [3:0] alu_op,
  output logic [1:0] ext_op,
  output logic       illegal
);

  always_comb begin
    cls    = C_ILL;
    alu_op = ALUOP_ADD;
    ext_op = EXTOP_SIGNED;
    unique case (opcode)
      OP_RTYPE: begin
        cls = C_R;
        unique case (funct)
          FN_ADDU: alu_op = ALUOP_ADD;
          FN_SUBU: alu_op = ALUOP_SUB;
          FN_AND:  alu_op = ALUOP_AND;
          FN_OR:   alu_op = ALUOP_OR;
          FN_SLT:  alu_op = ALUOP_SLT;
          default: cls = C_ILL;
        endcase
      end
      OP_ADDIU: cls = C_I;
      OP_ORI: begin
        cls    = C_I;
        alu_op = ALUOP_OR;
        ext_op = EXTOP_ZERO;
      end
      OP_LUI: begin
        cls    = C_I;
        alu_op = ALUOP_LUI;
        ext_op = EXTOP_ZERO;
      end
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILL;
    endcase
  end

  assign illegal = (cls == C_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for a shared MIPS
// datapath. `MULTICYCLE_MEM_WAIT_EN adds mem_ready stalls on memory states.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] ext_op,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t     state;
  iclass_t    cls;
  logic [3:0] dec_alu_op;
  logic [1:0] dec_ext_op;
  logic       dec_illegal;
  logic       ready;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign ready = 1'b1;
`endif

  mctrl_decode u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (cls),
    .alu_op  (dec_alu_op),
    .ext_op  (dec_ext_op),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      unique case (state)
        S_FETCH:  if (ready) state <= S_DECODE;
        S_DECODE: begin
          unique case (cls)
            C_R:       state <= S_EXEC_R;
            C_I:       state <= S_EXEC_I;
            C_LW, C_SW: state <= S_MEMADR;
            C_BEQ:     state <= S_BRANCH;
            C_J, C_JAL: state <= S_JUMP;
            default:   state <= S_FETCH;
          endcase
        end
        S_EXEC_R: state <= S_WB_R;
        S_EXEC_I: state <= S_WB_I;
        S_MEMADR: state <= (cls == C_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (ready) state <= S_MEMWB;
        S_MEMWR:  if (ready) state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Reset gates every strobe so an abandoned instruction writes nothing.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = ALUOP_ADD;
    ext_op     = EXTOP_ZERO;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = ready;
          pc_write  = ready;
          alu_src_b = 2'd1;
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          ext_op    = EXTOP_SIGNED;
          illegal   = dec_illegal;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = dec_alu_op;
        end
        S_WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = 2'd1;
          instr_done = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = dec_alu_op;
          ext_op    = dec_ext_op;
        end
        S_WB_I: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          ext_op    = EXTOP_SIGNED;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = ready;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALUOP_SUB;
          pc_src     = 2'd1;
          pc_write   = zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = 2'd2;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          if (cls == C_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;

endmodule
